// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// Module  : mux_pkg
// Purpose : Shared types and constants for the registered N:1 selector.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int              ERR_CNT_W   = 8;
  localparam logic [7:0]      ERR_CNT_MAX = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/mux_n_1.sv
// ----------------------------------------------------------------------------
// Module  : mux_n_1
// Purpose : Combinational N:1 select over a flattened input bus with range flag.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mux_n_1 #(
  parameter  int WIDTH = 32,
  parameter  int N     = 3,
  localparam int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   y,
  output logic               in_range
);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SELW:0] C_N = (SELW + 1)'(N);

  assign in_range = ({1'b0, sel} < C_N);

  // Explicit decode keeps out-of-range codes from reading past the bus.
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) begin
        y = d[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_n_1_reg.sv
// ----------------------------------------------------------------------------
// Module  : mux_n_1_reg
// Purpose : Handshaked, registered N:1 operand selector with error counting.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mux_n_1_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 3,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   d,
  input  logic [SELW-1:0]      sel,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  output logic [WIDTH-1:0]     y,
  output logic [SELW-1:0]      y_sel,
  output logic                 y_valid,
  input  logic                 out_ready,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_y;
  logic [SELW-1:0]      r_y_sel;
  logic                 r_sel_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0]     w_mux_y;
  logic                 w_in_range;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_bad;

  mux_n_1 #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_mux (
    .d        (d),
    .sel      (sel),
    .y        (w_mux_y),
    .in_range (w_in_range)
  );

  assign sel_ready = (r_state == ST_EMPTY) || out_ready;
  assign w_accept  = sel_valid && sel_ready;
  assign w_load    = w_accept && w_in_range;
  assign w_bad     = w_accept && !w_in_range;

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = ST_FULL;
    end else if (w_bad) begin
      w_state_nxt = ((r_state == ST_EMPTY) || out_ready) ? ST_EMPTY : ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_y       <= '0;
      r_y_sel   <= '0;
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel_err <= w_bad;
      if (w_load) begin
        r_y     <= w_mux_y;
        r_y_sel <= sel;
      end
      // A clear coinciding with an error leaves that error counted.
      if (err_clr) begin
        r_err_cnt <= w_bad ? ERR_CNT_W'(1) : '0;
      end else if (w_bad && (r_err_cnt != ERR_CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign y       = r_y;
  assign y_sel   = r_y_sel;
  assign y_valid = (r_state == ST_FULL);
  assign sel_err = r_sel_err;
  assign err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: doc/mux_n_1_reg.md
# mux_n_1_reg

Parametrised, registered N-to-1 operand selector for the multicycle datapath, succeeding the fixed 3:1 combinational select. It accepts a select with a valid/ready handshake and captures the chosen WIDTH-bit input into a one-entry output register. It holds that value until the consumer takes it, rejects out-of-range selects with an error pulse and a saturating error count, and so lets ALU-source and PC-source selection sit between multicycle state transitions.

## Interface
- WIDTH, 32, data width of each input and of y
- N, 3, number of inputs (N >= 2); SELW = $clog2(N) derived as localparam
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- d  in  N*WIDTH  flattened inputs; input i is d[i*WIDTH +: WIDTH]
- sel  in  SELW  requested input index
- sel_valid  in  1  sel is presented
- sel_ready  out  1  block can accept sel this cycle
- y  out  WIDTH  registered selected data
- y_sel  out  SELW  index that produced y
- y_valid  out  1  y holds an untaken value
- out_ready  in  1  consumer takes y this cycle
- sel_err  out  1  one-cycle pulse: out-of-range select was accepted
- err_cnt  out  8  saturating count of rejected selects
- err_clr  in  1  clears err_cnt

## Operation
- FSM has two states: EMPTY (y_valid=0) and FULL (y_valid=1). y_valid is the state bit.
- sel_ready = (state==EMPTY) || out_ready. It is combinational and has no dependency on sel_valid.
- A select is accepted when sel_valid && sel_ready.
- Valid accept (sel < N):
  - y <= d[sel] as sampled in the accept cycle
  - y_sel <= sel
  - next state FULL
- Invalid accept (sel >= N, possible only when N is not a power of 2):
  - The select is consumed and dropped.
  - y and y_sel are unchanged.
  - sel_err <= 1 for one cycle.
  - err_cnt increments, saturating at 255.
  - Next state: EMPTY if the prior state was EMPTY or out_ready=1; otherwise FULL.
- Drain without accept: FULL && out_ready && !accept -> EMPTY. y and y_sel keep their last value.
- Simultaneous drain and valid accept: state stays FULL with the new y. This gives back-to-back throughput of 1 per cycle.
- FULL && !out_ready:
  - sel_ready=0
  - y, y_sel and y_valid are held stable
  - d changes are ignored
- err_clr:
  - err_clr with no error in the same cycle -> err_cnt <= 0.
  - err_clr together with an error -> err_cnt <= 1.
- d is never sampled outside an accept cycle.

## Timing
- Reset (rst_n=0 at a clk edge) values: y=0, y_sel=0, y_valid=0, sel_err=0, err_cnt=0, state EMPTY.
- Reset dominates all other inputs. An in-flight FULL value is discarded.
- sel_ready during reset follows the same formula as in operation. It is 1 because the state is EMPTY.
- Latency: accept at edge k -> y/y_valid visible after edge k. This is 1 cycle.
- sel_err is asserted in the cycle after the invalid accept and deasserts the next cycle unless another invalid accept occurs.
- There are no combinational paths from d or sel to any output.
- The only combinational input-to-output path is out_ready -> sel_ready.

## Structure
- Shared package mux_pkg:
  - state enum {ST_EMPTY, ST_FULL}
  - localparam ERR_CNT_W = 8
  - ERR_CNT_MAX = 8'hFF
- Sub-module mux_n_1: purely combinational, parametrised by WIDTH and N. It indexes the flattened d and outputs in_range = (sel < N).
- mux_n_1_reg instantiates mux_n_1 once and contains the FSM, output register and error counter.

## Test plan
All scenarios use WIDTH=8, N=3, and d = {8'hCC, 8'hBB, 8'hAA} (input 0 = AA).
- Reset: hold rst_n=0 for 2 cycles with sel_valid=1 -> y=0, y_valid=0, err_cnt=0. sel_ready=1 throughout.
- Basic select: sel=1, sel_valid=1 for one cycle with out_ready=0 -> next cycle y=BB, y_sel=1, y_valid=1, sel_ready=0. Change d[1] to 8'h11 -> y stays BB.
- Back-to-back: out_ready=1 with sel=0, 2, 1 on consecutive cycles -> y = AA, CC, BB on consecutive cycles, y_valid high for 3 cycles, then drops.
- Backpressure: with FULL, out_ready=0 and sel_valid=1 sel=2 for 5 cycles -> sel_ready=0 and y unchanged. Raise out_ready -> the accept happens that cycle and y=CC on the next cycle.
- Invalid select: sel=3 while EMPTY -> sel_err pulses for 1 cycle, err_cnt=1, y_valid stays 0, y unchanged. Repeat 300 times -> err_cnt=255. Assert err_clr with a simultaneous sel=3 -> err_cnt=1.
- Reset mid-operation: FULL with y=BB, drive rst_n=0 for one cycle -> y=0, y_valid=0, err_cnt=0. The next valid sel=2 yields y=CC after 1 cycle.
